// File: rtl/gate_stimulus_checker.sv
// gate_stimulus_checker
//
// Drives the four two-input vectors into an external combinational gate and
// checks the gate's response against the truth table selected by sel. It
// counts mismatches, saturating at 7, and reports pass or fail when the run
// ends.
//
// Parameters:
//   SETTLE (0..15) - extra cycles each vector is held before it is sampled
//   LOOPS  (1..15) - number of full passes over the four vectors
//
// Ports (8-bit tile pins):
//   io_in[0]   clk    single clock, rising edge
//   io_in[1]   rst_n  asynchronous active-low reset
//   io_in[2]   start  a run starts on its rising edge while idle or done
//   io_in[3]   dut_y  output of the gate under test
//   io_in[4]   unused
//   io_in[7:5] sel    expected function: 0 AND, 1 NAND, 2 OR, 3 NOR,
//                     4 XOR, 5 XNOR, 6 NOT a, 7 BUF a
//   io_out[0]  a, io_out[1] b       stimulus to the gate under test
//   io_out[2]  busy, io_out[3] pass, io_out[4] fail
//   io_out[7:5] errcnt              saturating mismatch count
//
// Optional feature macro: GATECHK_STOP_ON_FAIL_EN
//   Defined:   the first mismatch ends the run, and a/b keep the failing
//              vector while the block is in DONE.
//   Undefined: every vector runs, and a/b return to 0 in DONE.
module gate_stimulus_checker #(
  parameter int SETTLE = 2,
  parameter int LOOPS  = 1
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
  localparam logic [3:0] LOOPS_LAST  = 4'(LOOPS - 1);
  // When SETTLE is 0, each vector is sampled in the same cycle it is driven.
  localparam state_t     VEC_ENTRY   = (SETTLE == 0) ? SAMPLE : DRIVE;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       dut_y;
  logic [2:0] sel;
  logic       unused_io;

  assign clk       = io_in[0];
  assign rst_n     = io_in[1];
  assign start     = io_in[2];
  assign dut_y     = io_in[3];
  assign sel       = io_in[7:5];
  assign unused_io = io_in[4];

  state_t     state_reg;
  logic       start_q_reg;
  logic [2:0] sel_reg;
  logic [2:0] errcnt_reg;
  logic [1:0] v_reg;
  logic [3:0] loop_reg;
  logic [3:0] settle_reg;
  logic       a_reg;
  logic       b_reg;
  logic       busy_reg;
  logic       pass_reg;
  logic       fail_reg;

  function automatic logic gate_fn(input logic [2:0] s, input logic x, input logic y);
    case (s)
      3'd0:    gate_fn = x & y;
      3'd1:    gate_fn = ~(x & y);
      3'd2:    gate_fn = x | y;
      3'd3:    gate_fn = ~(x | y);
      3'd4:    gate_fn = x ^ y;
      3'd5:    gate_fn = ~(x ^ y);
      3'd6:    gate_fn = ~x;
      default: gate_fn = x;
    endcase
  endfunction

  // Expected response for each vector {b,a} under the captured function.
  logic [3:0] exp_tt;
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_tt
      assign exp_tt[gi] = gate_fn(sel_reg, (gi % 2) == 1, (gi / 2) == 1);
    end
  endgenerate

  logic       start_edge;
  logic       mismatch;
  logic       last_sample;
  logic [1:0] v_next;
  logic [2:0] errcnt_next;

  always_comb begin
    start_edge  = start & ~start_q_reg;
    mismatch    = (dut_y != exp_tt[v_reg]);
    last_sample = (v_reg == 2'd3) && (loop_reg == LOOPS_LAST);
    v_next      = v_reg + 2'd1;
    errcnt_next = errcnt_reg;
    if (mismatch && errcnt_reg != 3'd7) begin
      errcnt_next = errcnt_reg + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      // Resets high so that a start held through reset release is not an edge.
      start_q_reg <= 1'b1;
      sel_reg     <= 3'd0;
      errcnt_reg  <= 3'd0;
      v_reg       <= 2'd0;
      loop_reg    <= 4'd0;
      settle_reg  <= 4'd0;
      a_reg       <= 1'b0;
      b_reg       <= 1'b0;
      busy_reg    <= 1'b0;
      pass_reg    <= 1'b0;
      fail_reg    <= 1'b0;
    end else begin
      start_q_reg <= start;
      case (state_reg)
        IDLE, DONE: begin
          if (start_edge) begin
            state_reg  <= VEC_ENTRY;
            sel_reg    <= sel;
            errcnt_reg <= 3'd0;
            v_reg      <= 2'd0;
            loop_reg   <= 4'd0;
            settle_reg <= 4'd0;
            a_reg      <= 1'b0;
            b_reg      <= 1'b0;
            busy_reg   <= 1'b1;
            pass_reg   <= 1'b0;
            fail_reg   <= 1'b0;
          end
        end
        DRIVE: begin
          if (settle_reg == SETTLE_LAST) begin
            state_reg  <= SAMPLE;
            settle_reg <= 4'd0;
          end else begin
            settle_reg <= settle_reg + 4'd1;
          end
        end
        SAMPLE: begin
`ifdef GATECHK_STOP_ON_FAIL_EN
          if (mismatch) begin
            // a/b keep the failing vector so it can be seen on the pins.
            state_reg  <= DONE;
            errcnt_reg <= errcnt_next;
            busy_reg   <= 1'b0;
            pass_reg   <= 1'b0;
            fail_reg   <= 1'b1;
          end else
`endif
          begin
            errcnt_reg <= errcnt_next;
            v_reg      <= v_next;
            if (v_reg == 2'd3) begin
              loop_reg <= loop_reg + 4'd1;
            end
            if (last_sample) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              a_reg     <= 1'b0;
              b_reg     <= 1'b0;
              pass_reg  <= (errcnt_next == 3'd0);
              fail_reg  <= (errcnt_next != 3'd0);
            end else begin
              state_reg <= VEC_ENTRY;
              a_reg     <= v_next[0];
              b_reg     <= v_next[1];
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign io_out = {errcnt_reg, fail_reg, pass_reg, busy_reg, b_reg, a_reg};

endmodule

// File: tb/tb_gate_stimulus_checker.sv
// Testbench for gate_stimulus_checker. It uses three instances:
//   u_dut0: SETTLE=2, LOOPS=1 (table-driven function runs, reset, start)
//   u_dut1: SETTLE=2, LOOPS=4 (errcnt saturation)
//   u_dut2: SETTLE=0, LOOPS=1 (single-cycle vectors)
// Each instance's gate under test is a behavioural model selected by mode.
module tb_gate_stimulus_checker;

`ifdef GATECHK_STOP_ON_FAIL_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  localparam int M_AND  = 0;
  localparam int M_ZERO = 1;
  localparam int M_XNOR = 2;
  localparam int M_BUFA = 3;
  localparam int M_OR   = 4;
  localparam int M_XOR  = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_s [3];
  logic [2:0] sel_s   [3];
  int         mode_s  [3];
  logic [7:0] in0, in1, in2;
  logic [7:0] out0, out1, out2;
  logic       y0, y1, y2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic model(input int m, input logic a, input logic b);
    case (m)
      M_AND:   model = a & b;
      M_ZERO:  model = 1'b0;
      M_XNOR:  model = ~(a ^ b);
      M_BUFA:  model = a;
      M_OR:    model = a | b;
      default: model = a ^ b;
    endcase
  endfunction

  assign y0  = model(mode_s[0], out0[0], out0[1]);
  assign y1  = model(mode_s[1], out1[0], out1[1]);
  assign y2  = model(mode_s[2], out2[0], out2[1]);
  assign in0 = {sel_s[0], 1'b0, y0, start_s[0], rst_n, clk};
  assign in1 = {sel_s[1], 1'b0, y1, start_s[1], rst_n, clk};
  assign in2 = {sel_s[2], 1'b0, y2, start_s[2], rst_n, clk};

  gate_stimulus_checker #(.SETTLE(2), .LOOPS(1)) u_dut0 (.io_in(in0), .io_out(out0));
  gate_stimulus_checker #(.SETTLE(2), .LOOPS(4)) u_dut1 (.io_in(in1), .io_out(out1));
  gate_stimulus_checker #(.SETTLE(0), .LOOPS(1)) u_dut2 (.io_in(in2), .io_out(out2));

  function automatic logic [7:0] get_out(input int k);
    case (k)
      0:       get_out = out0;
      1:       get_out = out1;
      default: get_out = out2;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulses start for one cycle, then follows the run until busy drops.
  // seq_ok reports whether every busy cycle showed the expected {b,a}.
  task automatic run(input int k, input int settle, input logic [2:0] s, input int mode,
                     output int busy_cnt, output int seq_ok, output logic [7:0] fin);
    logic [7:0] o;
    sel_s[k]   = s;
    mode_s[k]  = mode;
    start_s[k] = 1'b1;
    @(negedge clk);
    start_s[k] = 1'b0;
    busy_cnt = 0;
    seq_ok   = 1;
    o = get_out(k);
    while (o[2] && busy_cnt < 200) begin
      if (int'(o[1:0]) != (busy_cnt / (settle + 1)) % 4) seq_ok = 0;
      busy_cnt++;
      @(negedge clk);
      o = get_out(k);
    end
    fin = o;
  endtask

  typedef struct {
    logic [2:0] sel;
    int         mode;
    int         busy;
    int         err;
    int         pass;
    int         fail;
    int         sf_busy;
    int         sf_err;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int         bc;
    int         sq;
    int         cnt;
    logic [7:0] fin;
    logic [7:0] held;

    tbl[0] = '{3'd0, M_AND,  12, 0, 1, 0, 12, 0};
    tbl[1] = '{3'd1, M_ZERO, 12, 3, 0, 1,  3, 1};
    tbl[2] = '{3'd2, M_OR,   12, 0, 1, 0, 12, 0};
    tbl[3] = '{3'd3, M_OR,   12, 4, 0, 1,  3, 1};
    tbl[4] = '{3'd4, M_XOR,  12, 0, 1, 0, 12, 0};
    tbl[5] = '{3'd5, M_XNOR, 12, 0, 1, 0, 12, 0};
    tbl[6] = '{3'd6, M_ZERO, 12, 2, 0, 1,  3, 1};

    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0;
      sel_s[k]   = 3'd0;
      mode_s[k]  = M_AND;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out0", int'(out0), 0);
    check("reset_out1", int'(out1), 0);
    check("reset_out2", int'(out2), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_out0", int'(out0), 0);

    // Table-driven runs on the SETTLE=2, LOOPS=1 instance.
    for (int i = 0; i < 7; i++) begin
      run(0, 2, tbl[i].sel, tbl[i].mode, bc, sq, fin);
      $display("[TB] run sel=%0d busy_cycles=%0d errcnt=%0d pass=%0d fail=%0d",
               tbl[i].sel, bc, fin[7:5], fin[3], fin[4]);
      check($sformatf("busy_cycles_%0d", i), bc, STOP_EN ? tbl[i].sf_busy : tbl[i].busy);
      check($sformatf("vector_seq_%0d", i), sq, 1);
      check($sformatf("errcnt_%0d", i), int'(fin[7:5]), STOP_EN ? tbl[i].sf_err : tbl[i].err);
      check($sformatf("pass_%0d", i), int'(fin[3]), tbl[i].pass);
      check($sformatf("fail_%0d", i), int'(fin[4]), tbl[i].fail);
      check($sformatf("ab_done_%0d", i), int'(fin[1:0]), 0);
    end

    // Saturation: 16 mismatches on the LOOPS=4 instance.
    run(1, 2, 3'd4, M_XNOR, bc, sq, fin);
    $display("[TB] run sat busy_cycles=%0d errcnt=%0d fail=%0d", bc, fin[7:5], fin[4]);
    check("sat_busy", bc, STOP_EN ? 3 : 48);
    check("sat_seq", sq, 1);
    check("sat_errcnt", int'(fin[7:5]), STOP_EN ? 1 : 7);
    check("sat_fail", int'(fin[4]), 1);

    // SETTLE=0: BUF a passes, NOT a against a buffer fails every vector.
    run(2, 0, 3'd7, M_BUFA, bc, sq, fin);
    $display("[TB] run s0 sel=7 busy_cycles=%0d errcnt=%0d pass=%0d", bc, fin[7:5], fin[3]);
    check("s0_buf_busy", bc, 4);
    check("s0_buf_seq", sq, 1);
    check("s0_buf_pass", int'(fin[3]), 1);
    run(2, 0, 3'd6, M_BUFA, bc, sq, fin);
    $display("[TB] run s0 sel=6 busy_cycles=%0d errcnt=%0d fail=%0d", bc, fin[7:5], fin[4]);
    check("s0_not_busy", bc, STOP_EN ? 1 : 4);
    check("s0_not_errcnt", int'(fin[7:5]), STOP_EN ? 1 : 4);
    check("s0_not_fail", int'(fin[4]), 1);

    // Reset mid-run, during vector 2, with start held high.
    sel_s[0]   = 3'd1;
    mode_s[0]  = M_ZERO;
    start_s[0] = 1'b1;
    @(negedge clk);
    repeat (7) @(negedge clk);
    check("midrun_vec", int'(out0[1:0]), STOP_EN ? 0 : 2);
    check("midrun_errcnt", int'(out0[7:5]), STOP_EN ? 1 : 2);
    #2 rst_n = 1'b0;
    #1;
    $display("[TB] async reset mid-run io_out=%02h", out0);
    check("async_reset_out", int'(out0), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (out0 != 8'h00) cnt++;
    end
    check("no_run_after_reset", cnt, 0);
    start_s[0] = 1'b0;
    @(negedge clk);
    run(0, 2, 3'd0, M_AND, bc, sq, fin);
    $display("[TB] run after reset busy_cycles=%0d errcnt=%0d pass=%0d", bc, fin[7:5], fin[3]);
    check("clean_run_busy", bc, 12);
    check("clean_run_errcnt", int'(fin[7:5]), 0);
    check("clean_run_pass", int'(fin[3]), 1);

    // Start held high through a run, with an extra edge while busy.
    sel_s[0]   = 3'd0;
    mode_s[0]  = M_AND;
    start_s[0] = 1'b1;
    @(negedge clk);
    bc = 0;
    while (out0[2] && bc < 200) begin
      if (bc == 4) start_s[0] = 1'b0;
      if (bc == 5) start_s[0] = 1'b1;
      bc++;
      @(negedge clk);
    end
    $display("[TB] run start-held busy_cycles=%0d pass=%0d", bc, out0[3]);
    check("held_start_busy", bc, 12);
    check("held_start_pass", int'(out0[3]), 1);
    held = out0;
    cnt  = 0;
    repeat (5) begin
      @(negedge clk);
      if (out0 != held) cnt++;
    end
    check("done_stable", cnt, 0);
    start_s[0] = 1'b0;
    @(negedge clk);
    start_s[0] = 1'b1;
    @(negedge clk);
    $display("[TB] restart from DONE io_out=%02h", out0);
    check("restart_busy_pass_fail", int'(out0[4:2]), 1);
    start_s[0] = 1'b0;
    bc = 0;
    while (out0[2] && bc < 200) begin
      bc++;
      @(negedge clk);
    end
    check("restart_busy", bc, 12);
    check("restart_pass", int'(out0[3]), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
